// File: rtl/mf_clken_gen.sv
// rtl/mf_clken_gen.sv - N-channel fractional clock-enable generator with phase reprogramming and lock flag
// Optional feature macro CLKEN_DUTY_EN: registered accumulator MSB per channel on clk_lvl.
module mf_clken_gen #(
  parameter int                      NUM_CH      = 4,
  parameter int                      ACC_W       = 32,
  parameter int                      LOCK_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = {4{32'h20000000}},
  parameter logic [NUM_CH*ACC_W-1:0] INIT_PHASE  = {32'h0, 32'h0, 32'h40000000, 32'h0}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_resync,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_lvl,
  output logic              locked
);
  localparam int               CNT_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [4:0]       NUM_CH_V  = 5'(NUM_CH);

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic              pend_q, pend_d;
  logic [3:0]        pend_ch_q, pend_ch_d;
  logic [ACC_W-1:0]  pend_inc_q, pend_inc_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              xfer, ch_ok, resync_hit, defer_hit;

  assign cfg_ready  = ~pend_q;
  assign xfer       = cfg_valid & ~pend_q;
  assign ch_ok      = {1'b0, cfg_ch} < NUM_CH_V;
  assign resync_hit = xfer & ch_ok & cfg_resync;
  assign defer_hit  = xfer & ch_ok & ~cfg_resync;

  assign ce      = ce_q;
  assign cfg_err = err_q;
  assign locked  = locked_q;

  always_comb begin
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_inc_d = pend_inc_q;
    err_d      = xfer & ~ch_ok;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    ce_d       = '0;
    if (!locked_q) begin
      if (lock_cnt_q == LOCK_LAST) locked_d = 1'b1;
      else lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
    if (resync_hit) begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end
    if (defer_hit) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg_ch;
      pend_inc_d = cfg_inc;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i] = sum[i][ACC_W-1:0];
      inc_d[i] = inc_q[i];
      ce_d[i]  = sum[i][ACC_W];
      // Deferred increment lands on the wrapping add, so that wrap still uses the old rate.
      if (pend_q && pend_ch_q == 4'(i) && (sum[i][ACC_W] || inc_q[i] == '0)) begin
        inc_d[i] = pend_inc_q;
        pend_d   = 1'b0;
      end
      if (resync_hit && cfg_ch == 4'(i)) begin
        acc_d[i] = cfg_phase;
        inc_d[i] = cfg_inc;
        ce_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= INIT_PHASE[i*ACC_W +: ACC_W];
        inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
      ce_q       <= '0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_inc_q <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
      ce_q       <= ce_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_inc_q <= pend_inc_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

`ifdef CLKEN_DUTY_EN
  logic [NUM_CH-1:0] lvl_q, lvl_d;

  always_comb begin
    lvl_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lvl_d[i] = (resync_hit && cfg_ch == 4'(i)) ? 1'b0 : acc_d[i][ACC_W-1];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_d;
  end

  assign clk_lvl = lvl_q;
`else
  assign clk_lvl = '0;
`endif

endmodule

// File: tb/tb_mf_clken_gen.sv
// tb/tb_mf_clken_gen.sv - randomized self-checking bench for mf_clken_gen against a segment-based rate model
module tb_mf_clken_gen;
  localparam int NUM_CH = 4;
  localparam int ACC_W = 32;
  localparam int LOCK = 1024;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_ch = '0;
  logic [31:0] cfg_inc = '0;
  logic [31:0] cfg_phase = '0;
  logic        cfg_resync = 1'b0;
  logic        cfg_err;
  logic [3:0]  ce;
  logic [3:0]  clk_lvl;
  logic        locked;

  mf_clken_gen dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_resync(cfg_resync),
    .cfg_err(cfg_err), .ce(ce), .clk_lvl(clk_lvl), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail = 0;

  // Each channel is a linear segment: position(k) = ph0 + (k - k0) * inc, unwrapped.
  longint unsigned m_ph0 [NUM_CH];
  longint unsigned m_inc [NUM_CH];
  int              m_k0  [NUM_CH];
  int              step;
  int              lock_start;
  bit              m_pend;
  int              m_pend_ch;
  longint unsigned m_pend_inc;
  logic [3:0]      e_ce, e_lvl;
  logic            e_err, e_ready, e_locked;

  logic [10:0] obs;
  assign obs = {ce, cfg_ready, cfg_err, locked, clk_lvl};
  localparam logic [10:0] RST_VEC = {4'b0, 1'b1, 1'b0, 1'b0, 4'b0};

  function automatic logic [10:0] exp_vec();
    return {e_ce, e_ready, e_err, e_locked, e_lvl};
  endfunction

  function automatic longint unsigned pos(int c, int k);
    return m_ph0[c] + longint'(k - m_k0[c]) * m_inc[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ph0[c] = (c == 1) ? 64'h4000_0000 : 64'h0;
      m_inc[c] = 64'h2000_0000;
      m_k0[c]  = 0;
    end
    step = 0; lock_start = 0; m_pend = 0;
    e_ce = '0; e_lvl = '0; e_err = 0; e_ready = 1; e_locked = 0;
  endtask

  task automatic tick();
    logic v, rs;
    int ch, rc, pc;
    longint unsigned ninc, nph, p;
    bit was_pend;
    v = cfg_valid; rs = cfg_resync; ch = int'(cfg_ch);
    ninc = {32'h0, cfg_inc}; nph = {32'h0, cfg_phase};
    @(posedge refclk); #1;
    step++;
    was_pend = m_pend;
    rc = -1;
    for (int c = 0; c < NUM_CH; c++)
      e_ce[c] = (step > m_k0[c]) && ((pos(c, step) >> ACC_W) != (pos(c, step - 1) >> ACC_W));
    pc = m_pend_ch;
    if (was_pend && (e_ce[pc] || m_inc[pc] == 0)) begin
      m_ph0[pc] = pos(pc, step) % MOD;
      m_k0[pc]  = step;
      m_inc[pc] = m_pend_inc;
      m_pend    = 0;
    end
    e_err = 0;
    if (v && !was_pend) begin
      if (ch >= NUM_CH) e_err = 1;
      else if (rs) begin
        e_ce[ch] = 0; m_ph0[ch] = nph; m_inc[ch] = ninc; m_k0[ch] = step;
        lock_start = step; rc = ch;
      end else begin
        m_pend = 1; m_pend_ch = ch; m_pend_inc = ninc;
      end
    end
    e_ready = !m_pend;
    e_locked = (step - lock_start) >= LOCK;
    for (int c = 0; c < NUM_CH; c++) begin
      p = pos(c, step);
`ifdef CLKEN_DUTY_EN
      e_lvl[c] = (c == rc) ? 1'b0 : p[31];
`else
      e_lvl[c] = 1'b0;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1; cfg_valid = 0;
    repeat (3) @(posedge refclk);
    #1;
    n_checks++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs, RST_VEC); end
    model_reset();
    rst = 0;
    for (int i = 0; i < 1030; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
      if (step == 6) begin
        n_checks++;
        if (ce[1:0] !== 2'b10) begin n_fail++; $display("FAIL ce1_offset got=%b exp=10", ce[1:0]); end
      end
      if (step == 8) begin
        n_checks++;
        if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL ce0_period got=%b exp=1", ce[0]); end
      end
      if (step == 1023) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%b exp=0", locked); end
      end
      if (step == 1024) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_1024 got=%b exp=1", locked); end
      end
    end
  endtask

  task automatic test_fractional();
    int cnt = 0;
    cfg_ch = 3; cfg_inc = 32'h15555555; cfg_phase = $urandom; cfg_resync = 1; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL frac_resync got=%h exp=%h", obs, exp_vec()); end
    for (int i = 0; i < 12000; i++) begin
      tick();
      if (ce[3]) cnt++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL frac_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
    end
    n_checks++;
    if (cnt < 999 || cnt > 1001) begin n_fail++; $display("FAIL frac_count got=%0d exp=1000+-1", cnt); end
  endtask

  task automatic test_deferred();
    int t0 = -1, t1 = -1, t2 = -1, n;
    n = 0;
    while (t0 < 0 && n < 20) begin
      tick(); n++;
      if (ce[0]) t0 = step;
    end
    repeat (2) tick();
    cfg_ch = 0; cfg_inc = 32'h10000000; cfg_resync = 0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL defer_ready_low got=%b exp=0", cfg_ready); end
    n = 0;
    while (t2 < 0 && n < 60) begin
      tick(); n++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL defer_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
      if (ce[0]) begin
        if (t1 < 0) t1 = step;
        else t2 = step;
      end
    end
    n_checks++;
    if (t0 < 0 || t1 - t0 != 8) begin n_fail++; $display("FAIL defer_gap_old got=%0d exp=8", t1 - t0); end
    n_checks++;
    if (t2 < 0 || t2 - t1 != 16) begin n_fail++; $display("FAIL defer_gap_new got=%0d exp=16", t2 - t1); end
    n_checks++;
    if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL defer_end got=%b%b exp=11", locked, cfg_ready);
    end
  endtask

  task automatic test_bad_ch();
    int pulses = 0;
    cfg_ch = 7; cfg_inc = $urandom; cfg_phase = $urandom; cfg_resync = 1'($urandom_range(0, 1)); cfg_valid = 1;
    tick();
    cfg_valid = 0;
    if (cfg_err) pulses++;
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL badch_first got=%h exp=%h", obs, exp_vec()); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_err) pulses++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL badch_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL badch_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_frozen();
    int r, hits = 0;
    cfg_ch = 2; cfg_inc = 0; cfg_phase = 0; cfg_resync = 1; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    r = step;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (ce[2]) hits++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL frozen_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
      if (step == r + 1023) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early got=%b exp=0", locked); end
      end
      if (step == r + 1024) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL relock got=%b exp=1", locked); end
      end
    end
    n_checks++;
    if (hits != 0) begin n_fail++; $display("FAIL frozen_ce got=%0d exp=0", hits); end
    cfg_ch = 2; cfg_inc = 32'h30000000; cfg_resync = 0; cfg_valid = 1;
    tick();
    cfg_valid = 0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL frozen_pend got=%b exp=0", cfg_ready); end
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL frozen_apply got=%b exp=1", cfg_ready); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL thaw_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      cfg_ch = (sel < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      sel = $urandom_range(0, 5);
      cfg_inc = (sel == 0) ? 32'h0 : (sel == 1) ? (32'h80000000 | $urandom) : (32'h01000000 | $urandom);
      cfg_phase = $urandom;
      cfg_resync = 1'($urandom_range(0, 1));
      cfg_valid = 1;
      tick();
      cfg_valid = 0;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_xfer step=%0d got=%h exp=%h", step, obs, exp_vec()); end
      repeat ($urandom_range(0, 12)) begin
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    int cnt = 0;
    cfg_ch = 0; cfg_inc = 32'h01000000; cfg_phase = 0; cfg_resync = 1; cfg_valid = 1;
    tick();
    cfg_inc = 32'h08000000; cfg_resync = 0;
    tick();
    cfg_valid = 0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_pending got=%b exp=0", cfg_ready); end
    #2 rst = 1;
    #1;
    n_checks++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL rstp_immediate got=%h exp=%h", obs, RST_VEC); end
    repeat (3) @(posedge refclk);
    #1;
    n_checks++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL rstp_hold got=%h exp=%h", obs, RST_VEC); end
    model_reset();
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ce[0]) cnt++;
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rstp_run step=%0d got=%h exp=%h", step, obs, exp_vec()); end
`ifdef CLKEN_DUTY_EN
      if (step == 4 || step == 7 || step == 8) begin
        n_checks++;
        if (clk_lvl[0] !== (step != 8)) begin n_fail++; $display("FAIL duty_lvl step=%0d got=%b", step, clk_lvl[0]); end
      end
`endif
    end
    n_checks++;
    if (cnt != 5) begin n_fail++; $display("FAIL rstp_ce0_count got=%0d exp=5", cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fractional();
    test_deferred();
    test_bad_ch();
    test_frozen();
    test_random();
    test_reset_mid_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
